// File: rtl/gc_arbiter.sv
// Round-robin arbiter that lets two requesters share one gC actuation block.
// Each grant runs a Start/Actuator handshake with timeouts that fall into a sticky FAULT state.
module gc_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned HOLD    = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] Req,
    input  logic       Actuator,
    input  logic       ClrErr,
    output logic       Start,
    output logic [1:0] Gnt,
    output logic [1:0] Done,
    output logic       Busy,
    output logic       Err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       ptr_q, ptr_d;
    logic       actMeta_q, actSync_q;
    logic       start_q, start_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;
    logic       winner;
    logic       active;

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        winner = Req[1];
        if (Req[0] && Req[1]) begin
            winner = ptr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if ((Req != 2'b00) && !actSync_q) begin
                    state_d = S_ARM;
                    owner_d = winner;
                end
            end
            S_ARM: begin
                if (actSync_q) begin
                    state_d = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!actSync_q) begin
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = ~owner_q;
            end
            S_FAULT: begin
                if (ClrErr && !actSync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One counter serves ARM/RELEASE timeouts and the HOLD length; it restarts on every state change.
    always_comb begin
        cnt_d = 8'd0;
        if ((state_d == state_q) &&
            ((state_q == S_ARM) || (state_q == S_HOLD) || (state_q == S_RELEASE))) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with the state register.
    always_comb begin
        active  = (state_d == S_ARM) || (state_d == S_HOLD) ||
                  (state_d == S_RELEASE) || (state_d == S_DONE);
        start_d = (state_d == S_ARM) || (state_d == S_HOLD);
        gnt_d   = 2'b00;
        if (active) begin
            gnt_d = owner_d ? 2'b10 : 2'b01;
        end
        done_d = 2'b00;
        if (state_d == S_DONE) begin
            done_d = owner_d ? 2'b10 : 2'b01;
        end
        busy_d = (state_d != S_IDLE);
        err_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            actMeta_q <= 1'b0;
            actSync_q <= 1'b0;
            start_q   <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            actMeta_q <= Actuator;
            actSync_q <= actMeta_q;
            start_q   <= start_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign Start = start_q;
    assign Gnt   = gnt_q;
    assign Done  = done_q;
    assign Busy  = busy_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_gc_arbiter.sv
// Scoreboard bench for gc_arbiter: the stimulus queues the expected completion or fault,
// and an independent monitor checks each Done pulse or Err rise against it.
module tb_gc_arbiter;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [1:0] Req;
    logic       Actuator;
    logic       ClrErr;
    logic       Start;
    logic [1:0] Gnt;
    logic [1:0] Done;
    logic       Busy;
    logic       Err;

    typedef struct {
        logic       isFault;
        logic [1:0] doneVal;
        int         startLen;
        int         relLen;
    } exp_t;

    exp_t expQ[$];
    exp_t expCur;
    int   checks   = 0;
    int   failures = 0;
    int   startLen = 0;
    int   relLen   = 0;
    logic errPrev  = 1'b0;

    gc_arbiter #(.TIMEOUT(16), .HOLD(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Actuator(Actuator), .ClrErr(ClrErr),
        .Start(Start), .Gnt(Gnt), .Done(Done), .Busy(Busy), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitStart(input logic level, input string name);
        int n = 0;
        while (Start !== level && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (Start !== level) checkOutput(name, int'(Start), int'(level));
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (Done == 2'b00 && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (Done == 2'b00) checkOutput(name, 0, 1);
    endtask

    task automatic waitErr(input string name);
        int n = 0;
        while (!Err && n < 80) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!Err) checkOutput(name, 0, 1);
    endtask

    // gC model: raise Actuator three cycles after Start, drop it once Start falls.
    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] expGnt,
                                 input logic dropReq, input logic stuckHigh);
        Req = req;
        waitStart(1'b1, "start_rise_timeout");
        checkOutput("gnt_at_start", Gnt, expGnt);
        if (dropReq) Req = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        Actuator = 1'b1;
        if (!stuckHigh) begin
            waitStart(1'b0, "start_fall_timeout");
            Actuator = 1'b0;
            waitDone("done_timeout");
        end
    endtask

    // Monitor: measures Start-high and RELEASE lengths, pops the scoreboard on each Done or Err rise.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            startLen = 0;
            relLen   = 0;
            errPrev  = 1'b0;
        end else begin
            checkOutput("gnt_legal", int'((Gnt != 2'b11) && (!Start || Gnt != 2'b00)), 1);
            if (Start) startLen++;
            else if (Busy && Done == 2'b00 && !Err) relLen++;
            if (Done != 2'b00 || (Err && !errPrev)) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_event", int'({Err, Done}), 0);
                end else begin
                    expCur = expQ.pop_front();
                    checkOutput("event_is_fault", int'(Err), int'(expCur.isFault));
                    checkOutput("done_value", Done, expCur.doneVal);
                    checkOutput("gnt_at_event", Gnt, expCur.doneVal);
                    checkOutput("start_len", startLen, expCur.startLen);
                    checkOutput("release_len", relLen, expCur.relLen);
                end
                startLen = 0;
                relLen   = 0;
            end
            errPrev = Err;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst_n = 1'b1; Req = 2'b00; Actuator = 1'b0; ClrErr = 1'b0;
        #2 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("rst_start", Start, 0);
        checkOutput("rst_gnt", Gnt, 0);
        checkOutput("rst_done", Done, 0);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_err", Err, 0);
        @(negedge Clk) Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Contention with both requests held: 01, 10, 01.
        expQ.push_back('{1'b0, 2'b01, 10, 3});
        applyStimulus(2'b11, 2'b01, 1'b0, 1'b0);
        expQ.push_back('{1'b0, 2'b10, 10, 3});
        applyStimulus(2'b11, 2'b10, 1'b0, 1'b0);
        expQ.push_back('{1'b0, 2'b01, 10, 3});
        applyStimulus(2'b11, 2'b01, 1'b1, 1'b0);
        repeat (10) @(posedge Clk);
        #1;

        // Single requester, Req dropped during ARM: exactly one Done, then idle.
        expQ.push_back('{1'b0, 2'b01, 10, 3});
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b0);
        @(posedge Clk); #1;
        checkOutput("done_one_cycle", Done, 0);
        checkOutput("busy_after_done", Busy, 0);
        repeat (10) @(posedge Clk);
        #1;

        // ARM timeout with Actuator stuck low.
        expQ.push_back('{1'b1, 2'b00, 16, 0});
        Req = 2'b10;
        waitStart(1'b1, "start_rise_timeout");
        checkOutput("gnt_timeout_seq", Gnt, 2'b10);
        Req = 2'b00;
        waitErr("arm_fault_timeout");
        checkOutput("fault_start", Start, 0);
        checkOutput("fault_gnt", Gnt, 0);
        checkOutput("fault_err", Err, 1);
        ClrErr = 1'b1;
        @(posedge Clk); #1;
        ClrErr = 1'b0;
        checkOutput("clr_err", Err, 0);
        checkOutput("clr_busy", Busy, 0);
        repeat (3) @(posedge Clk);
        #1;

        // RELEASE timeout with Actuator stuck high; ClrErr waits for Actuator to drop.
        expQ.push_back('{1'b1, 2'b00, 10, 16});
        applyStimulus(2'b01, 2'b01, 1'b1, 1'b1);
        waitErr("release_fault_timeout");
        ClrErr = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("clr_ignored_act_high", Err, 1);
        Actuator = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkOutput("clr_waits_sync", Err, 1);
        @(posedge Clk); #1;
        checkOutput("clr_after_sync", Err, 0);
        ClrErr = 1'b0;
        repeat (3) @(posedge Clk);
        #1;

        // Asynchronous reset in the middle of HOLD.
        Req = 2'b01;
        waitStart(1'b1, "start_rise_timeout");
        Req = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        Actuator = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        checkOutput("start_in_hold", Start, 1);
        #2 Rst_n = 1'b0;
        #1;
        checkOutput("async_rst_start", Start, 0);
        checkOutput("async_rst_gnt", Gnt, 0);
        checkOutput("async_rst_busy", Busy, 0);
        Actuator = 1'b0;
        Req = 2'b11;
        repeat (2) @(posedge Clk);
        @(negedge Clk) Rst_n = 1'b1;
        #1;
        checkOutput("no_early_grant", Gnt, 0);
        expQ.push_back('{1'b0, 2'b01, 10, 3});
        applyStimulus(2'b11, 2'b01, 1'b1, 1'b0);

        repeat (20) @(posedge Clk);
        #1;
        checkOutput("queue_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
